// File: rtl/segre_dmem_responder.sv
// segre_dmem_responder
//
// Responder side of the core's memop interface. It takes one load/store request at a time
// and performs it on a word-wide data memory that has no byte enables. Sub-word stores are
// done as a read-modify-write. Sub-word loads are extracted from the word and then sign- or
// zero-extended. Misaligned or illegal requests and memory timeouts return err_o=1.
//
// Ports:
//   clk_i, rsn_i          clock, asynchronous active-low reset
//   req_valid_i/ready_o   request handshake
//   memop_rd_i/wr_i       load / store select (exactly one must be set)
//   memop_type_i          0=BYTE, 1=HALF, 2=WORD (3 is illegal)
//   memop_sign_ext_i      sign-extend a sub-word load
//   addr_i, wdata_i       byte address, right-aligned store data
//   rsp_valid_o/ready_i   response handshake
//   rdata_o, err_o        extended load data (0 for stores and errors), error flag
//   mem_*                 word memory port: req/gnt handshake, separate rvalid return
module segre_dmem_responder #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rsn_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  memop_rd_i,
  input  logic                  memop_wr_i,
  input  logic [1:0]            memop_type_i,
  input  logic                  memop_sign_ext_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rdata_o,
  output logic                  err_o,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-3:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

  localparam logic [1:0] TypeByte = 2'd0;
  localparam logic [1:0] TypeHalf = 2'd1;
  localparam logic [1:0] TypeWord = 2'd2;

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdWait,
    StWrReq,
    StResp
  } state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    op_rd_q, op_rd_d;
  logic [1:0]              type_q, type_d;
  logic                    sext_q, sext_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  // Only the low half is needed later: full-word stores load mem_wdata directly at accept.
  logic [15:0]             wdata_q, wdata_d;
  logic                    req_ready_q, req_ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [31:0]             mem_wdata_q, mem_wdata_d;

  logic                    req_err;
  logic [CntW-1:0]         cnt_inc;
  logic                    timeout;
  logic [7:0]              byte_sel;
  logic [15:0]             half_sel;
  logic [31:0]             load_ext;
  logic [31:0]             merged;

  assign req_err = (memop_rd_i == memop_wr_i) ||
                   (memop_type_i == 2'd3) ||
                   ((memop_type_i == TypeHalf) && addr_i[0]) ||
                   ((memop_type_i == TypeWord) && (addr_i[1:0] != 2'b00));

  assign cnt_inc = cnt_q + CntW'(1);
  assign timeout = (cnt_inc == CntMax);

  // Lane extraction and extension of a returned read word.
  always_comb begin
    byte_sel = mem_rdata_i[7:0];
    unique case (addr_q[1:0])
      2'd0: byte_sel = mem_rdata_i[7:0];
      2'd1: byte_sel = mem_rdata_i[15:8];
      2'd2: byte_sel = mem_rdata_i[23:16];
      2'd3: byte_sel = mem_rdata_i[31:24];
      default: byte_sel = mem_rdata_i[7:0];
    endcase
    half_sel = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (type_q)
      TypeByte: load_ext = {{24{sext_q & byte_sel[7]}}, byte_sel};
      TypeHalf: load_ext = {{16{sext_q & half_sel[15]}}, half_sel};
      default:  load_ext = mem_rdata_i;
    endcase
  end

  // Merge the store data into the word read back for a sub-word store.
  always_comb begin
    merged = mem_rdata_i;
    if (type_q == TypeByte) begin
      unique case (addr_q[1:0])
        2'd0: merged[7:0]   = wdata_q[7:0];
        2'd1: merged[15:8]  = wdata_q[7:0];
        2'd2: merged[23:16] = wdata_q[7:0];
        2'd3: merged[31:24] = wdata_q[7:0];
        default: merged = mem_rdata_i;
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q;
    end else begin
      merged[15:0] = wdata_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    op_rd_d     = op_rd_q;
    type_d      = type_q;
    sext_d      = sext_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          op_rd_d = memop_rd_i;
          type_d  = memop_type_i;
          sext_d  = memop_sign_ext_i;
          addr_d  = addr_i;
          wdata_d = wdata_i[15:0];
          rdata_d = '0;
          err_d   = 1'b0;
          if (req_err) begin
            err_d   = 1'b1;
            state_d = StResp;
          end else if (memop_wr_i && (memop_type_i == TypeWord)) begin
            mem_wdata_d = wdata_i;
            state_d     = StWrReq;
          end else begin
            state_d = StRdReq;
          end
        end
      end
      StRdReq: begin
        if (mem_gnt_i) begin
          state_d = StRdWait;
        end else if (timeout) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = StResp;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StRdWait: begin
        if (mem_rvalid_i) begin
          if (op_rd_q) begin
            rdata_d = load_ext;
            state_d = StResp;
          end else begin
            mem_wdata_d = merged;
            state_d     = StWrReq;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = StResp;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StWrReq: begin
        if (mem_gnt_i) begin
          state_d = StResp;
        end else if (timeout) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = StResp;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered from the next state so they change together with it.
    req_ready_d = (state_d == StIdle);
    rsp_valid_d = (state_d == StResp);
    mem_req_d   = (state_d == StRdReq) || (state_d == StWrReq);
    mem_we_d    = (state_d == StWrReq);
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      op_rd_q     <= 1'b0;
      type_q      <= 2'd0;
      sext_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_rd_q     <= op_rd_d;
      type_q      <= type_d;
      sext_q      <= sext_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = addr_q[ADDR_WIDTH-1:2];
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: doc/segre_dmem_responder.md
Name: segre_dmem_responder

Overview:
- Responder side of the core's memop interface: accepts one load/store request (rd/wr, data type, sign-extend, address, store data) from the execute/memory stage and performs it on a word-wide data memory.
- The memory port has a req/gnt handshake and a separate rvalid return, with no byte enables.
- Sub-word stores are done as read-modify-write. Sub-word loads are extracted and sign- or zero-extended.
- Misalignment and memory timeout are reported as errors; one outstanding request at a time.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- TIMEOUT_CYCLES, 255, maximum cycles spent in RD_REQ, RD_WAIT or WR_REQ before an error response (counter width $clog2(TIMEOUT_CYCLES+1)).

Ports:
- clk_i  in  1  clock
- rsn_i  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  responder can accept a request
- memop_rd_i  in  1  load
- memop_wr_i  in  1  store
- memop_type_i  in  2  memop_data_type_e: BYTE=0, HALF=1, WORD=2
- memop_sign_ext_i  in  1  sign-extend load result
- addr_i  in  ADDR_WIDTH  byte address
- wdata_i  in  32  store data, right-aligned
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  consumer takes response
- rdata_o  out  32  extended load data (0 for stores and errors)
- err_o  out  1  misaligned, illegal or timeout
- mem_req_o  out  1  memory request
- mem_gnt_i  in  1  memory grant
- mem_we_o  out  1  write
- mem_addr_o  out  ADDR_WIDTH-2  word address
- mem_wdata_o  out  32  write word
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  32  read word

Behaviour:
- Reset (async, rsn_i=0): state IDLE; timeout counter and all latched request fields 0. Outputs: req_ready_o=1, rsp_valid_o=0, err_o=0, rdata_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0. Reset mid-transaction drops the transaction silently; late mem_gnt_i/mem_rvalid_i are ignored while in IDLE.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP.
- req_ready_o=1 only in IDLE. A request is accepted on req_valid_i & req_ready_o; all request fields are latched.
- Transitions from IDLE on accept:
  - Error cases go to RESP with err_o=1 and no memory access: memop_rd_i==memop_wr_i; memop_type_i==3; HALF with addr[0]=1; WORD with addr[1:0]!=0.
  - Load, or BYTE/HALF store: go to RD_REQ.
  - WORD store: go to WR_REQ with mem_wdata_o=wdata_i.
- RD_REQ: mem_req_o=1, mem_we_o=0, mem_addr_o=addr[ADDR_WIDTH-1:2]. On mem_gnt_i, go to RD_WAIT.
- RD_WAIT: mem_req_o=0. mem_rvalid_i is honoured only in this state (earliest one cycle after grant).
  - Load: on rvalid, select byte addr[1:0] or half addr[1], extend per the latched sign_ext (WORD passes through), register into rdata_o, go to RESP.
  - Sub-word store: on rvalid, merge wdata_i[7:0] into byte lane addr[1:0] (BYTE) or wdata_i[15:0] into half lane addr[1] (HALF), register into mem_wdata_o, go to WR_REQ.
- WR_REQ: mem_req_o=1, mem_we_o=1, same word address. On mem_gnt_i, go to RESP; no rvalid is expected for writes.
- RESP: rsp_valid_o=1. rdata_o and err_o stay stable until rsp_ready_i; then go to IDLE.
  - A new request can be accepted no earlier than the cycle after the handshake (no bypass).
- Timeout counter:
  - Cleared on every state change; increments each cycle spent in RD_REQ, RD_WAIT or WR_REQ.
  - On reaching TIMEOUT_CYCLES without gnt/rvalid: go to RESP with err_o=1, rdata_o=0, mem_req_o dropped.
  - If gnt/rvalid arrives in the same cycle as the timeout, the gnt/rvalid wins.
- Best-case latency, load or sub-word-store read phase: accept at cycle 0, mem_req_o at cycle 1 with same-cycle gnt, rvalid at cycle 2.
  - Load: rsp_valid_o at cycle 3.
  - Sub-word store: write request at cycle 3, rsp_valid_o at cycle 4.
  - WORD store: write request at cycle 1, rsp_valid_o at cycle 2.

Test Plan:
- Signed LB: mem word 0x80FF_7F01 at 0x100; LB addr 0x103, sign_ext=1 -> rdata_o=0xFFFF_FF80, err_o=0, rsp_valid_o at cycle 3 with zero-wait memory. LBU addr 0x101 -> 0x0000_007F.
- SH read-modify-write: word 0xAABB_CCDD at 0x200; SH addr 0x202, wdata 0x1234 -> one read, then write 0x1234_CCDD to word address 0x80; rsp err_o=0, rdata_o=0.
- Misaligned: LW addr 0x102 -> RESP next cycle, err_o=1, mem_req_o never asserted. SH addr 0x201 -> same.
- Grant stall and response backpressure: mem_gnt_i held low 5 cycles on a WORD store, then rsp_ready_i low 3 cycles -> mem_req_o/mem_addr_o stable throughout, rsp_valid_o/rdata_o held, req_ready_o=0 until the cycle after the handshake.
- Timeout: TIMEOUT_CYCLES=8, mem_rvalid_i never asserted on LW -> err_o=1, rdata_o=0 after 8 cycles in RD_WAIT; next LW completes normally.
- Async reset asserted in RD_WAIT -> outputs at reset values immediately; stale mem_rvalid_i after reset release produces no response; memop_rd_i=memop_wr_i=1 request -> err_o=1.
